// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, MAC hookup and result handshake of the dot-product sequencer.
interface mac_seq_ctrl_if #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 8
);
  logic               start;
  logic [CNT_W-1:0]   len_in;
  logic               op_valid;
  logic               op_ready;
  logic [LEN-1:0]     op_in1;
  logic [LEN-1:0]     op_in2;
  logic [LEN-1:0]     mac_a;
  logic [LEN-1:0]     mac_b;
  logic [LEN-1:0]     mac_pre;
  logic [2*LEN-1:0]   mac_out;
  logic               busy;
  logic [LEN-1:0]     result;
  logic               result_valid;
  logic               result_ready;
  logic               sat_flag;

  modport master (
    output start, len_in, op_valid, op_in1, op_in2, mac_out, result_ready,
    input  op_ready, mac_a, mac_b, mac_pre, busy, result, result_valid, sat_flag
  );

  modport slave (
    input  start, len_in, op_valid, op_in1, op_in2, mac_out, result_ready,
    output op_ready, mac_a, mac_b, mac_pre, busy, result, result_valid, sat_flag
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer time-sharing one external signed MAC across a streamed vector.
// Optional MAC_SAT_EN: saturate each step to LEN bits and report it on sat_flag.
module mac_seq_ctrl #(
  parameter int unsigned LEN   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [LEN-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               sat_q, sat_d;
  logic               op_ready_q;
  logic               busy_q;
  logic               res_valid_q;
  logic               beat_c;
  logic [LEN-1:0]     narrow_c;
  logic               clamp_c;

`ifdef MAC_SAT_EN
  // Result fits in LEN bits only when the top LEN+1 bits are all sign copies.
  logic [LEN:0] hi_c;
  assign hi_c    = bus.mac_out[2*LEN-1:LEN-1];
  assign clamp_c = !((&hi_c) || !(|hi_c));

  always_comb begin
    narrow_c = bus.mac_out[LEN-1:0];
    if (clamp_c) begin
      narrow_c = bus.mac_out[2*LEN-1] ? {1'b1, {(LEN-1){1'b0}}}
                                      : {1'b0, {(LEN-1){1'b1}}};
    end
  end
`else
  assign clamp_c  = 1'b0;
  assign narrow_c = bus.mac_out[LEN-1:0];
`endif

  assign bus.mac_a        = bus.op_in1;
  assign bus.mac_b        = bus.op_in2;
  assign bus.mac_pre      = acc_q;
  assign bus.op_ready     = op_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result       = acc_q;
  assign bus.result_valid = res_valid_q;
  assign bus.sat_flag     = sat_q;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    beat_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          sat_d = 1'b0;
          if (bus.len_in != '0) begin
            len_d   = bus.len_in;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        beat_c = bus.op_valid && op_ready_q;
        if (beat_c) begin
          acc_d = narrow_c;
          cnt_d = cnt_q + CNT_W'(1);
          sat_d = sat_q | clamp_c;
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      op_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      op_ready_q  <= (state_d == ST_RUN);
      busy_q      <= (state_d != ST_IDLE);
      res_valid_q <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl with an external MAC and a dot-product reference model.
module tb_mac_seq_ctrl;
  localparam int unsigned LEN   = 8;
  localparam int unsigned CNT_W = 8;
  localparam int MAXV = (1 << (LEN - 1)) - 1;
  localparam int MINV = -MAXV - 1;

  logic clk;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   qa[$];
  int   qb[$];

  mac_seq_ctrl_if #(.LEN(LEN), .CNT_W(CNT_W)) bus ();

  mac_seq_ctrl #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural stand-in for the combinational MAC: in1*in2 + preResult
  logic signed [2*LEN-1:0] ma, mb, mp;
  assign ma = {{LEN{bus.mac_a[LEN-1]}}, bus.mac_a};
  assign mb = {{LEN{bus.mac_b[LEN-1]}}, bus.mac_b};
  assign mp = {{LEN{bus.mac_pre[LEN-1]}}, bus.mac_pre};
  assign bus.mac_out = ma * mb + mp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input int n, output int res, output bit sat);
    int acc;
    int x;
    acc = 0;
    sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      x = qa[i] * qb[i] + acc;
`ifdef MAC_SAT_EN
      if (x > MAXV) begin
        acc = MAXV; sat = 1'b1;
      end else if (x < MINV) begin
        acc = MINV; sat = 1'b1;
      end else begin
        acc = x;
      end
`else
      acc = x & ((1 << LEN) - 1);
      if (acc > MAXV) acc = acc - (1 << LEN);
`endif
    end
    res = acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job up to result_valid; gap_pct is the chance of idling op_valid.
  task automatic drive_job(input int n, input int gap_pct, output int res, output bit sat,
                           output int lat, output int beats, output bit to);
    bit will_beat;
    bus.start    = 1'b1;
    bus.len_in   = CNT_W'(n);
    bus.op_valid = 1'b0;
    step();
    bus.start = 1'b0;
    lat   = 1;
    beats = 0;
    to    = 1'b0;
    while (bus.result_valid !== 1'b1) begin
      if (lat > 4 * n + 50) begin
        to = 1'b1;
        break;
      end
      if (beats < n && $urandom_range(99) >= gap_pct) begin
        bus.op_valid = 1'b1;
        bus.op_in1   = LEN'(qa[beats]);
        bus.op_in2   = LEN'(qb[beats]);
      end else begin
        bus.op_valid = 1'b0;
      end
      will_beat = bus.op_valid && bus.op_ready;
      step();
      if (will_beat) beats++;
      lat++;
    end
    bus.op_valid = 1'b0;
    res = int'($signed(bus.result));
    sat = bus.sat_flag;
  endtask

  task automatic take_result();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op_in1 = 8'h5A;
    bus.op_in2 = 8'hA5;
    step();
    step();
    vectors++;
    if ({bus.op_ready, bus.busy, bus.result_valid, bus.sat_flag} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.op_ready, bus.busy, bus.result_valid, bus.sat_flag});
    end
    vectors++;
    if (bus.result !== '0 || bus.mac_pre !== '0) begin
      miscompares++;
      $display("FAIL reset_data: result=%0d mac_pre=%0d expected 0", bus.result, bus.mac_pre);
    end
    vectors++;
    if (bus.mac_a !== 8'h5A || bus.mac_b !== 8'hA5) begin
      miscompares++;
      $display("FAIL mac_passthru: mac_a=%h mac_b=%h expected 5a a5", bus.mac_a, bus.mac_b);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int res, lat, beats; bit sat, to;
    qa = '{2, -4, 7};
    qb = '{3, 5, 1};
    drive_job(3, 0, res, sat, lat, beats, to);
    vectors++;
    if (to || res !== -7 || sat !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got %0d sat=%0d to=%0d expected -7 sat=0", res, sat, to);
    end
    vectors++;
    if (lat !== 4 || beats !== 3) begin
      miscompares++;
      $display("FAIL basic_latency: lat=%0d beats=%0d expected 4 3", lat, beats);
    end
    take_result();
  endtask

  task automatic test_empty();
    bus.start  = 1'b1;
    bus.len_in = '0;
    step();
    bus.start = 1'b0;
    vectors++;
    if (bus.result_valid !== 1'b1 || bus.result !== '0 || bus.op_ready !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_done: rv=%0d result=%0d op_ready=%0d busy=%0d expected 1 0 0 1",
               bus.result_valid, bus.result, bus.op_ready, bus.busy);
    end
    take_result();
    vectors++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_idle: rv=%0d busy=%0d expected 0 0", bus.result_valid, bus.busy);
    end
  endtask

  task automatic test_sat();
    int res, lat, beats, exp_res; bit sat, to, exp_sat;
    qa = '{100, 1};
    qb = '{2, 1};
`ifdef MAC_SAT_EN
    exp_res = 127; exp_sat = 1'b1;
`else
    exp_res = -55; exp_sat = 1'b0;
`endif
    drive_job(2, 0, res, sat, lat, beats, to);
    vectors++;
    if (to || res !== exp_res || sat !== exp_sat) begin
      miscompares++;
      $display("FAIL sat_case: got %0d sat=%0d to=%0d expected %0d sat=%0d", res, sat, to, exp_res, exp_sat);
    end
    take_result();
  endtask

  task automatic test_gaps();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int beats;
    bit will_beat;
    bus.start  = 1'b1;
    bus.len_in = CNT_W'(4);
    step();
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      bus.op_valid = pat[i];
      bus.op_in1   = 8'd1;
      bus.op_in2   = 8'd1;
      bus.start    = (i == 2);
      bus.len_in   = (i == 2) ? CNT_W'(9) : CNT_W'(4);
      vectors++;
      if (bus.op_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL gaps_ready[%0d]: got %0d expected 1", i, bus.op_ready);
      end
      will_beat = bus.op_valid && bus.op_ready;
      step();
      if (will_beat) beats++;
    end
    bus.op_valid = 1'b0;
    bus.start    = 1'b0;
    vectors++;
    if (beats !== 4 || bus.result_valid !== 1'b1 || bus.result !== 8'd4 || bus.op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_result: beats=%0d rv=%0d result=%0d op_ready=%0d expected 4 1 4 0",
               beats, bus.result_valid, bus.result, bus.op_ready);
    end
    take_result();
  endtask

  task automatic test_hold_done();
    int res, lat, beats; bit sat, to;
    qa = '{3, -2};
    qb = '{5, 7};
    drive_job(2, 0, res, sat, lat, beats, to);
    vectors++;
    if (to || res !== 1) begin
      miscompares++;
      $display("FAIL hold_result: got %0d to=%0d expected 1", res, to);
    end
    bus.result_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.result_valid !== 1'b1 || bus.result !== 8'd1) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: rv=%0d result=%0d expected 1 1", i, bus.result_valid, bus.result);
      end
    end
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    bus.len_in       = CNT_W'(3);
    step();
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    vectors++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: rv=%0d busy=%0d expected 0 0", bus.result_valid, bus.busy);
    end
    step();
    vectors++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_no_job: busy=%0d op_ready=%0d expected 0 0", bus.busy, bus.op_ready);
    end
  endtask

  task automatic test_reset_mid();
    int res, lat, beats; bit sat, to;
    bus.start  = 1'b1;
    bus.len_in = CNT_W'(5);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.op_valid = 1'b1;
      bus.op_in1   = 8'd9;
      bus.op_in2   = 8'd7;
      reset        = (i == 2);
      step();
    end
    reset        = 1'b0;
    bus.op_valid = 1'b0;
    vectors++;
    if ({bus.op_ready, bus.busy, bus.result_valid, bus.sat_flag} !== 4'b0000 ||
        bus.result !== '0 || bus.mac_pre !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: flags=%b result=%0d mac_pre=%0d expected 0000 0 0",
               {bus.op_ready, bus.busy, bus.result_valid, bus.sat_flag}, bus.result, bus.mac_pre);
    end
    qa = '{-3};
    qb = '{-3};
    drive_job(1, 0, res, sat, lat, beats, to);
    vectors++;
    if (to || res !== 9 || lat !== 2) begin
      miscompares++;
      $display("FAIL post_reset_job: got %0d lat=%0d to=%0d expected 9 lat=2", res, lat, to);
    end
    take_result();
  endtask

  task automatic test_random();
    int n, res, lat, beats, exp_res; bit sat, to, exp_sat;
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(0, 12);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(int'($urandom_range(0, 255)) - 128);
        qb.push_back((j % 3 == 0) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 255)) - 128);
      end
      model(n, exp_res, exp_sat);
      drive_job(n, 35, res, sat, lat, beats, to);
      vectors++;
      if (to || res !== exp_res || sat !== exp_sat || beats !== n) begin
        miscompares++;
        $display("FAIL random_job[%0d]: n=%0d got %0d sat=%0d beats=%0d to=%0d expected %0d sat=%0d beats=%0d",
                 j, n, res, sat, beats, to, exp_res, exp_sat, n);
      end
      repeat ($urandom_range(0, 2)) step();
      take_result();
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.len_in       = '0;
    bus.op_valid     = 1'b0;
    bus.op_in1       = '0;
    bus.op_in2       = '0;
    bus.result_ready = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_sat();
    test_gaps();
    test_hold_done();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that time-shares one combinational signed MAC unit to compute a dot product over a streamed vector of operand pairs.
- Accepts a job (start + length), consumes operand pairs over a valid/ready stream, and feeds the running accumulator back as the MAC's pre-result.
- Narrows each MAC result to LEN bits, then presents the final sum over a result valid/ready handshake.
- Sits between the PE operand buffers and the MAC instance in the ALU.

Parameters:
LEN, 8, operand/accumulator width in bits (signed two's complement)
CNT_W, 8, width of job length and element counter; max vector length 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
len_in  input  CNT_W  number of operand pairs in job; sampled with start
op_valid  input  1  operand pair valid
op_ready  output  1  controller accepts operand pair
op_in1  input  LEN  signed operand A
op_in2  input  LEN  signed operand B
mac_a  output  LEN  to MAC in1; equals op_in1 (combinational)
mac_b  output  LEN  to MAC in2; equals op_in2 (combinational)
mac_pre  output  LEN  to MAC preResult; equals acc register
mac_out  input  2*LEN  signed MAC result in1*in2+preResult
busy  output  1  high in RUN and DONE
result  output  LEN  final accumulator value; valid when result_valid
result_valid  output  1  result available
result_ready  input  1  consumer takes result
sat_flag  output  1  sticky: some step saturated in current job

Behaviour:
- Reset values: state=IDLE, acc=0, cnt=0, len_r=0, op_ready=0, busy=0, result_valid=0, result=0, sat_flag=0. mac_a/mac_b follow inputs; mac_pre=0.
- IDLE:
  - op_ready=0.
  - On start=1 and len_in!=0: len_r<=len_in, acc<=0, cnt<=0, sat_flag<=0; next state RUN.
  - On start=1 and len_in==0: acc<=0, sat_flag<=0; next state DONE (empty dot product yields 0).
- RUN:
  - op_ready=1.
  - Beat = op_valid & op_ready.
  - On a beat: acc<=narrow(mac_out), cnt<=cnt+1.
  - If the beat is the last one (cnt==len_r-1): next state DONE.
  - Without a beat, all state holds. Gaps in op_valid are allowed and arbitrary.
- DONE:
  - op_ready=0, result_valid=1, result=acc.
  - On result_ready=1: next state IDLE, result_valid<=0. Same-cycle start is ignored; a new job is taken no earlier than the following cycle in IDLE.
  - result holds stable while result_valid=1 and result_ready=0.
- start while busy: ignored, no queueing.
- Latency: the first operand is accepted in the cycle after start. For N pairs with op_valid held high, result_valid rises N+1 cycles after the start cycle. Minimum job-to-job spacing is N+2 cycles.
- narrow(x): depends on MAC_SAT_EN (see Optional Feature). Treats mac_out as signed 2*LEN.
- Reset asserted in any state, including mid-RUN or DONE, returns to reset values on that edge. The partial job and any pending result are discarded.
- cnt and len_r are CNT_W bits and never wrap, because cnt < len_r <= 2^CNT_W-1.

Optional Feature:
MAC_SAT_EN
- Defined:
  - If mac_out > 2^(LEN-1)-1, narrow returns 2^(LEN-1)-1.
  - If mac_out < -2^(LEN-1), narrow returns -2^(LEN-1).
  - Otherwise narrow returns mac_out[LEN-1:0].
  - Any clamp on a beat sets sat_flag; sat_flag stays set until the next job start or reset.
- Undefined:
  - narrow returns mac_out[LEN-1:0] (wrap-around).
  - sat_flag is tied to 0.

Test Plan:
- LEN=8, start with len_in=3; pairs (2,3), (-4,5), (7,1), op_valid held high -> result=-7 (6-20+7), result_valid 4 cycles after start, sat_flag=0.
- start with len_in=0 -> DONE next cycle, result=0, no op_ready pulse; result_ready=1 -> back to IDLE.
- len_in=2; pairs (100,2), (1,1):
  - With MAC_SAT_EN -> step 1 clamps to 127, final result=127, sat_flag=1.
  - Without -> step 1 wraps to -56, final result=-55, sat_flag=0.
- len_in=4 with op_valid toggling 1,0,0,1,1,0,1, pairs all (1,1) -> exactly 4 beats accepted, result=4; start pulsed mid-RUN has no effect.
- In DONE, hold result_ready=0 for 5 cycles -> result and result_valid stable; then result_ready=1 with start=1 same cycle -> IDLE, job not taken.
- reset asserted after 2 of 5 beats -> next cycle all outputs at reset values; new job len_in=1, pair (-3,-3) -> result=9.
